// File: rtl/mem_stage_if.sv
// Data-memory bus between the MEM stage (master) and the memory (slave).
// Single outstanding req/ack transaction; rdata is valid in the ack cycle.
interface mem_stage_if #(
    parameter int ADDR_W = 32
);
    logic              dmem_req;
    logic              dmem_we;
    logic [ADDR_W-1:0] dmem_addr;
    logic [3:0]        dmem_be;
    logic [31:0]       dmem_wdata;
    logic [31:0]       dmem_rdata;
    logic              dmem_ack;

    modport master (
        output dmem_req, dmem_we, dmem_addr, dmem_be, dmem_wdata,
        input  dmem_rdata, dmem_ack
    );

    modport slave (
        input  dmem_req, dmem_we, dmem_addr, dmem_be, dmem_wdata,
        output dmem_rdata, dmem_ack
    );
endinterface

// File: rtl/mem_stage.sv
// MEM pipeline stage: drives load/store bus transactions and the MEM/WB register.
// Optional MEM_ALIGN_CHECK_EN: misaligned accesses raise exc_align instead of being force-aligned.
module mem_stage #(
    parameter int ADDR_W = 32,
    parameter int RD_W   = 5
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            ex_valid,
    input  logic [31:0]     ex_alu,
    input  logic [31:0]     ex_sdata,
    input  logic            ex_mem_read,
    input  logic            ex_mem_write,
    input  logic [1:0]      ex_size,
    input  logic            ex_signed,
    input  logic [RD_W-1:0] ex_rd,
    input  logic            ex_reg_write,
    output logic            stall,
    mem_stage_if.master     dmem,
    output logic            wb_valid,
    output logic [31:0]     wb_alu,
    output logic [31:0]     wb_load,
    output logic            wb_memtoreg,
    output logic [RD_W-1:0] wb_rd,
    output logic            wb_reg_write
`ifdef MEM_ALIGN_CHECK_EN
    ,
    output logic            exc_align
`endif
);

    typedef enum logic {
        IDLE,
        ACCESS
    } state_t;

    state_t            state_q, state_d;

    logic              req_q, req_d;
    logic              we_q, we_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [3:0]        be_q, be_d;
    logic [31:0]       wdata_q, wdata_d;
    logic [1:0]        size_q, size_d;
    logic              sgn_q, sgn_d;
    logic [RD_W-1:0]   rd_q, rd_d;
    logic              rw_q, rw_d;
    logic [31:0]       alu_q, alu_d;

    logic              wbv_q, wbv_d;
    logic [31:0]       wba_q, wba_d;
    logic [31:0]       wbl_q, wbl_d;
    logic              wbm_q, wbm_d;
    logic [RD_W-1:0]   wbr_q, wbr_d;
    logic              wbw_q, wbw_d;

    logic              mem_op;
    logic [ADDR_W-1:0] ex_addr;
    logic [3:0]        ex_be;
    logic [31:0]       ex_wdata;

`ifdef MEM_ALIGN_CHECK_EN
    logic              exc_q, exc_d;
    logic              misaligned;

    assign misaligned = ((ex_size == 2'b01) && ex_alu[0]) ||
                        (ex_size[1] && (ex_alu[1:0] != 2'b00));
`endif

    function automatic logic [31:0] extract(input logic [31:0] d, input logic [1:0] a,
                                            input logic [1:0] sz, input logic sx);
        logic [7:0]  b;
        logic [15:0] h;
        logic [31:0] r;
        case (a)
            2'd0:    b = d[7:0];
            2'd1:    b = d[15:8];
            2'd2:    b = d[23:16];
            default: b = d[31:24];
        endcase
        h = a[1] ? d[31:16] : d[15:0];
        if (sz == 2'b00)
            r = sx ? {{24{b[7]}}, b} : {24'h000000, b};
        else if (sz == 2'b01)
            r = sx ? {{16{h[15]}}, h} : {16'h0000, h};
        else
            r = d;
        return r;
    endfunction

    assign mem_op = ex_valid && (ex_mem_read || ex_mem_write);

    // Without the alignment check, low address bits are cleared so the bus never sees a misaligned access.
    always_comb begin
        ex_addr = ex_alu[ADDR_W-1:0];
`ifndef MEM_ALIGN_CHECK_EN
        if (ex_size == 2'b01)
            ex_addr[0] = 1'b0;
        else if (ex_size[1])
            ex_addr[1:0] = 2'b00;
`endif
    end

    always_comb begin
        ex_be    = '0;
        ex_wdata = '0;
        case (ex_size)
            2'b00: begin
                ex_be    = 4'b0001 << ex_addr[1:0];
                ex_wdata = {4{ex_sdata[7:0]}};
            end
            2'b01: begin
                ex_be    = ex_addr[1] ? 4'b1100 : 4'b0011;
                ex_wdata = {2{ex_sdata[15:0]}};
            end
            default: begin
                ex_be    = '1;
                ex_wdata = ex_sdata;
            end
        endcase
    end

    always_comb begin
        state_d = state_q;
        req_d   = req_q;
        we_d    = we_q;
        addr_d  = addr_q;
        be_d    = be_q;
        wdata_d = wdata_q;
        size_d  = size_q;
        sgn_d   = sgn_q;
        rd_d    = rd_q;
        rw_d    = rw_q;
        alu_d   = alu_q;
        wbv_d   = wbv_q;
        wba_d   = wba_q;
        wbl_d   = wbl_q;
        wbm_d   = wbm_q;
        wbr_d   = wbr_q;
        wbw_d   = wbw_q;
`ifdef MEM_ALIGN_CHECK_EN
        exc_d   = 1'b0;
`endif
        case (state_q)
            IDLE: begin
                if (!ex_valid) begin
                    wbv_d = 1'b0;
                end else if (!mem_op) begin
                    wbv_d = 1'b1;
                    wba_d = ex_alu;
                    wbm_d = 1'b0;
                    wbr_d = ex_rd;
                    wbw_d = ex_reg_write;
`ifdef MEM_ALIGN_CHECK_EN
                end else if (misaligned) begin
                    wbv_d = 1'b1;
                    wba_d = ex_alu;
                    wbm_d = 1'b0;
                    wbr_d = ex_rd;
                    wbw_d = 1'b0;
                    exc_d = 1'b1;
`endif
                end else begin
                    req_d   = 1'b1;
                    we_d    = ex_mem_write;
                    addr_d  = ex_addr;
                    be_d    = ex_be;
                    wdata_d = ex_wdata;
                    size_d  = ex_size;
                    sgn_d   = ex_signed;
                    rd_d    = ex_rd;
                    rw_d    = ex_reg_write;
                    alu_d   = ex_alu;
                    wbv_d   = 1'b0;
                    state_d = ACCESS;
                end
            end
            ACCESS: begin
                if (dmem.dmem_ack) begin
                    req_d   = 1'b0;
                    wbv_d   = 1'b1;
                    wba_d   = alu_q;
                    wbr_d   = rd_q;
                    if (!we_q) begin
                        wbl_d = extract(dmem.dmem_rdata, addr_q[1:0], size_q, sgn_q);
                        wbm_d = 1'b1;
                        wbw_d = rw_q;
                    end else begin
                        wbm_d = 1'b0;
                        wbw_d = 1'b0;
                    end
                    state_d = IDLE;
                end else begin
                    wbv_d = 1'b0;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            req_q   <= 1'b0;
            we_q    <= 1'b0;
            addr_q  <= '0;
            be_q    <= '0;
            wdata_q <= '0;
            size_q  <= '0;
            sgn_q   <= 1'b0;
            rd_q    <= '0;
            rw_q    <= 1'b0;
            alu_q   <= '0;
            wbv_q   <= 1'b0;
            wba_q   <= '0;
            wbl_q   <= '0;
            wbm_q   <= 1'b0;
            wbr_q   <= '0;
            wbw_q   <= 1'b0;
`ifdef MEM_ALIGN_CHECK_EN
            exc_q   <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            req_q   <= req_d;
            we_q    <= we_d;
            addr_q  <= addr_d;
            be_q    <= be_d;
            wdata_q <= wdata_d;
            size_q  <= size_d;
            sgn_q   <= sgn_d;
            rd_q    <= rd_d;
            rw_q    <= rw_d;
            alu_q   <= alu_d;
            wbv_q   <= wbv_d;
            wba_q   <= wba_d;
            wbl_q   <= wbl_d;
            wbm_q   <= wbm_d;
            wbr_q   <= wbr_d;
            wbw_q   <= wbw_d;
`ifdef MEM_ALIGN_CHECK_EN
            exc_q   <= exc_d;
`endif
        end
    end

    assign stall           = (state_q == ACCESS);
    assign dmem.dmem_req   = req_q;
    assign dmem.dmem_we    = we_q;
    assign dmem.dmem_addr  = addr_q;
    assign dmem.dmem_be    = be_q;
    assign dmem.dmem_wdata = wdata_q;
    assign wb_valid        = wbv_q;
    assign wb_alu          = wba_q;
    assign wb_load         = wbl_q;
    assign wb_memtoreg     = wbm_q;
    assign wb_rd           = wbr_q;
    assign wb_reg_write    = wbw_q;
`ifdef MEM_ALIGN_CHECK_EN
    assign exc_align       = exc_q;
`endif

endmodule

// File: tb/tb_mem_stage.sv
// Directed-vector bench for mem_stage; the bench plays the data memory.
// Honours MEM_ALIGN_CHECK_EN for the misaligned-word case.
module tb_mem_stage;

    logic        clk = 1'b0;
    logic        rst;
    logic        ex_valid;
    logic [31:0] ex_alu;
    logic [31:0] ex_sdata;
    logic        ex_mem_read;
    logic        ex_mem_write;
    logic [1:0]  ex_size;
    logic        ex_signed;
    logic [4:0]  ex_rd;
    logic        ex_reg_write;
    logic        stall;
    logic        wb_valid;
    logic [31:0] wb_alu;
    logic [31:0] wb_load;
    logic        wb_memtoreg;
    logic [4:0]  wb_rd;
    logic        wb_reg_write;
`ifdef MEM_ALIGN_CHECK_EN
    logic        exc_align;
`endif

    int n_vec = 0;
    int n_err = 0;
    int stalls;

    mem_stage_if #(.ADDR_W(32)) dmem ();

    mem_stage #(.ADDR_W(32), .RD_W(5)) dut (
        .clk          (clk),
        .rst          (rst),
        .ex_valid     (ex_valid),
        .ex_alu       (ex_alu),
        .ex_sdata     (ex_sdata),
        .ex_mem_read  (ex_mem_read),
        .ex_mem_write (ex_mem_write),
        .ex_size      (ex_size),
        .ex_signed    (ex_signed),
        .ex_rd        (ex_rd),
        .ex_reg_write (ex_reg_write),
        .stall        (stall),
        .dmem         (dmem.master),
        .wb_valid     (wb_valid),
        .wb_alu       (wb_alu),
        .wb_load      (wb_load),
        .wb_memtoreg  (wb_memtoreg),
        .wb_rd        (wb_rd),
        .wb_reg_write (wb_reg_write)
`ifdef MEM_ALIGN_CHECK_EN
        ,
        .exc_align    (exc_align)
`endif
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        ex_valid     = 1'b0;
        ex_alu       = '0;
        ex_sdata     = '0;
        ex_mem_read  = 1'b0;
        ex_mem_write = 1'b0;
        ex_size      = 2'b00;
        ex_signed    = 1'b0;
        ex_rd        = '0;
        ex_reg_write = 1'b0;
    endtask

    task automatic issue(input logic rd_en, input logic wr_en, input logic [1:0] sz,
                         input logic sx, input logic [31:0] addr, input logic [31:0] sd,
                         input logic [4:0] rd, input logic rw);
        ex_valid     = 1'b1;
        ex_mem_read  = rd_en;
        ex_mem_write = wr_en;
        ex_size      = sz;
        ex_signed    = sx;
        ex_alu       = addr;
        ex_sdata     = sd;
        ex_rd        = rd;
        ex_reg_write = rw;
    endtask

    // Called in the first ACCESS cycle; ack goes high in the ack_at-th stalled cycle.
    task automatic wait_ack(input int ack_at, input logic [31:0] rdata, output int n);
        n = 0;
        for (int i = 0; i < 20; i++) begin
            if (!stall) break;
            n++;
            if (n == ack_at) begin
                dmem.dmem_ack   = 1'b1;
                dmem.dmem_rdata = rdata;
            end
            tick();
            dmem.dmem_ack = 1'b0;
        end
        check("ack_bound", {31'd0, stall}, 32'd0);
    endtask

    initial begin
        rst             = 1'b1;
        dmem.dmem_ack   = 1'b0;
        dmem.dmem_rdata = '0;
        idle_inputs();
        tick();
        tick();
        check("rst_stall", {31'd0, stall}, 32'd0);
        check("rst_req", {31'd0, dmem.dmem_req}, 32'd0);
        check("rst_wbv", {31'd0, wb_valid}, 32'd0);
        check("rst_wbw", {31'd0, wb_reg_write}, 32'd0);
        check("rst_addr", dmem.dmem_addr, 32'd0);
        rst = 1'b0;
        tick();

        // ALU op: one-cycle pass-through, no bus activity
        issue(1'b0, 1'b0, 2'b10, 1'b0, 32'h1234, 32'h0, 5'd5, 1'b1);
        tick();
        check("alu_wbv", {31'd0, wb_valid}, 32'd1);
        check("alu_wba", wb_alu, 32'h1234);
        check("alu_m2r", {31'd0, wb_memtoreg}, 32'd0);
        check("alu_rd", {27'd0, wb_rd}, 32'd5);
        check("alu_wbw", {31'd0, wb_reg_write}, 32'd1);
        check("alu_req", {31'd0, dmem.dmem_req}, 32'd0);
        idle_inputs();
        tick();
        check("bubble_wbv", {31'd0, wb_valid}, 32'd0);

        // lb signed @0x103, ack in third ACCESS cycle
        issue(1'b1, 1'b0, 2'b00, 1'b1, 32'h103, 32'h0, 5'd7, 1'b1);
        tick();
        check("lb_req", {31'd0, dmem.dmem_req}, 32'd1);
        check("lb_we", {31'd0, dmem.dmem_we}, 32'd0);
        check("lb_addr", dmem.dmem_addr, 32'h103);
        check("lb_be", {28'd0, dmem.dmem_be}, 32'h8);
        check("lb_wbv_busy", {31'd0, wb_valid}, 32'd0);
        wait_ack(3, 32'h80FF_FFFF, stalls);
        check("lb_stalls", stalls, 32'd3);
        check("lb_wbv", {31'd0, wb_valid}, 32'd1);
        check("lb_load", wb_load, 32'hFFFF_FF80);
        check("lb_m2r", {31'd0, wb_memtoreg}, 32'd1);
        check("lb_rd", {27'd0, wb_rd}, 32'd7);
        check("lb_wbw", {31'd0, wb_reg_write}, 32'd1);
        check("lb_wba", wb_alu, 32'h103);
        check("lb_req_drop", {31'd0, dmem.dmem_req}, 32'd0);
        idle_inputs();
        tick();
        check("lb_after_wbv", {31'd0, wb_valid}, 32'd0);

        // sh @0x102
        issue(1'b0, 1'b1, 2'b01, 1'b0, 32'h102, 32'hAAAA_BEEF, 5'd3, 1'b1);
        tick();
        check("sh_we", {31'd0, dmem.dmem_we}, 32'd1);
        check("sh_addr", dmem.dmem_addr, 32'h102);
        check("sh_be", {28'd0, dmem.dmem_be}, 32'hC);
        check("sh_wdata", dmem.dmem_wdata, 32'hBEEF_BEEF);
        wait_ack(2, 32'h0, stalls);
        check("sh_stalls", stalls, 32'd2);
        check("sh_wbv", {31'd0, wb_valid}, 32'd1);
        check("sh_wbw", {31'd0, wb_reg_write}, 32'd0);
        check("sh_m2r", {31'd0, wb_memtoreg}, 32'd0);
        idle_inputs();
        tick();

        // lhu @0x102, immediate ack, next op accepted right after
        issue(1'b1, 1'b0, 2'b01, 1'b0, 32'h102, 32'h0, 5'd9, 1'b1);
        tick();
        check("lhu_be", {28'd0, dmem.dmem_be}, 32'hC);
        wait_ack(1, 32'h8001_0000, stalls);
        check("lhu_stalls", stalls, 32'd1);
        check("lhu_load", wb_load, 32'h0000_8001);
        issue(1'b0, 1'b0, 2'b10, 1'b0, 32'h55AA, 32'h0, 5'd2, 1'b1);
        tick();
        check("next_wbv", {31'd0, wb_valid}, 32'd1);
        check("next_wba", wb_alu, 32'h55AA);
        check("next_m2r", {31'd0, wb_memtoreg}, 32'd0);
        idle_inputs();
        tick();

        // sb @0x101 with read also set: store wins
        issue(1'b1, 1'b1, 2'b00, 1'b0, 32'h101, 32'h1234_56A5, 5'd4, 1'b1);
        tick();
        check("sb_we", {31'd0, dmem.dmem_we}, 32'd1);
        check("sb_be", {28'd0, dmem.dmem_be}, 32'h2);
        check("sb_wdata", dmem.dmem_wdata, 32'hA5A5_A5A5);
        wait_ack(1, 32'hFFFF_FFFF, stalls);
        check("sb_wbw", {31'd0, wb_reg_write}, 32'd0);
        idle_inputs();
        tick();

        // lh signed @0x100
        issue(1'b1, 1'b0, 2'b01, 1'b1, 32'h100, 32'h0, 5'd6, 1'b1);
        tick();
        check("lh_be", {28'd0, dmem.dmem_be}, 32'h3);
        wait_ack(2, 32'h1234_F00D, stalls);
        check("lh_load", wb_load, 32'hFFFF_F00D);
        idle_inputs();
        tick();

        // lbu @0x102
        issue(1'b1, 1'b0, 2'b00, 1'b0, 32'h102, 32'h0, 5'd8, 1'b1);
        tick();
        check("lbu_be", {28'd0, dmem.dmem_be}, 32'h4);
        wait_ack(1, 32'h00AB_0000, stalls);
        check("lbu_load", wb_load, 32'h0000_00AB);
        idle_inputs();
        tick();

        // ack while IDLE does nothing
        dmem.dmem_ack   = 1'b1;
        dmem.dmem_rdata = 32'hDEAD_BEEF;
        tick();
        dmem.dmem_ack   = 1'b0;
        check("idle_ack_wbv", {31'd0, wb_valid}, 32'd0);
        check("idle_ack_req", {31'd0, dmem.dmem_req}, 32'd0);
        check("idle_ack_stall", {31'd0, stall}, 32'd0);

        // reset mid-ACCESS, then a late ack
        issue(1'b1, 1'b0, 2'b10, 1'b0, 32'h200, 32'h0, 5'd1, 1'b1);
        tick();
        check("pre_rst_req", {31'd0, dmem.dmem_req}, 32'd1);
        #2 rst = 1'b1;
        #1;
        check("mid_rst_req", {31'd0, dmem.dmem_req}, 32'd0);
        check("mid_rst_stall", {31'd0, stall}, 32'd0);
        check("mid_rst_wbv", {31'd0, wb_valid}, 32'd0);
        check("mid_rst_addr", dmem.dmem_addr, 32'd0);
        idle_inputs();
        tick();
        rst             = 1'b0;
        dmem.dmem_ack   = 1'b1;
        dmem.dmem_rdata = 32'h1111_1111;
        tick();
        dmem.dmem_ack   = 1'b0;
        check("late_ack_wbv", {31'd0, wb_valid}, 32'd0);
        check("late_ack_req", {31'd0, dmem.dmem_req}, 32'd0);
        check("late_ack_stall", {31'd0, stall}, 32'd0);

        // lw @0x101
        issue(1'b1, 1'b0, 2'b10, 1'b0, 32'h101, 32'h0, 5'd12, 1'b1);
        tick();
`ifdef MEM_ALIGN_CHECK_EN
        check("mis_req", {31'd0, dmem.dmem_req}, 32'd0);
        check("mis_stall", {31'd0, stall}, 32'd0);
        check("mis_exc", {31'd0, exc_align}, 32'd1);
        check("mis_wbv", {31'd0, wb_valid}, 32'd1);
        check("mis_wbw", {31'd0, wb_reg_write}, 32'd0);
        idle_inputs();
        tick();
        check("mis_exc_clr", {31'd0, exc_align}, 32'd0);
`else
        check("lw_addr", dmem.dmem_addr, 32'h100);
        check("lw_be", {28'd0, dmem.dmem_be}, 32'hF);
        wait_ack(1, 32'hCAFE_F00D, stalls);
        check("lw_load", wb_load, 32'hCAFE_F00D);
        check("lw_rd", {27'd0, wb_rd}, 32'd12);
        idle_inputs();
        tick();
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
